echo_queue: RTL and testbench

Parametrised echo block: accepts `say` requests (method id plus payload), buffers up to DEPTH of them in order, and returns each one as a `heard` indication once it has aged at least DELAY cycles and the consumer is ready. It is the multi-outstanding successor to the single-slot echo. It sits between the request-side portal and the indication-side portal, and applies back-pressure on the request side when full.

---
 rtl/echo_queue.sv | 144 ++++++++++++++
 tb/tb_echo_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/echo_queue.sv
// echo_queue: DEPTH-entry FIFO that echoes say requests as heard indications after DELAY cycles.
// Optional feature macro: ECHO_QUEUE_SEQ_EN adds per-entry sequence tags on indication_heard_seq.
`default_nettype none

module echo_queue #(
    parameter int METH_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int DELAY      = 1,
    parameter int SEQ_WIDTH  = 8
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         request_say__ENA,
    input  logic [METH_WIDTH-1:0]        request_say_meth,
    input  logic [DATA_WIDTH-1:0]        request_say_v,
    output logic                         request_say__RDY,
    output logic                         indication_heard__ENA,
    output logic [METH_WIDTH-1:0]        indication_heard_meth,
    output logic [DATA_WIDTH-1:0]        indication_heard_v,
    input  logic                         indication_heard__RDY,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef ECHO_QUEUE_SEQ_EN
    ,
    output logic [SEQ_WIDTH-1:0]         indication_heard_seq
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [3:0]    DLY  = 4'(DELAY);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (DELAY < 0) || (DELAY > 15) || (SEQ_WIDTH < 1)) begin : g_param_check
        $error("echo_queue: unsupported parameter set");
    end

    logic [METH_WIDTH-1:0] meth_q [DEPTH];
    logic [DATA_WIDTH-1:0] v_q    [DEPTH];
    logic [3:0]            age_q  [DEPTH];
    logic [PW-1:0]         rd_q, rd_d;
    logic [PW-1:0]         wr_q, wr_d;
    logic [CW-1:0]         count_q, count_d;

    logic          acc;
    logic          deq;
    logic          occ   [DEPTH];
    logic          aged  [DEPTH];
    logic [PW-1:0] off   [DEPTH];

    assign request_say__RDY      = (count_q != FULL);
    assign acc                   = request_say__ENA & request_say__RDY;
    assign indication_heard__ENA = (count_q != '0) & aged[rd_q] & indication_heard__RDY;
    assign deq                   = indication_heard__ENA;

    assign indication_heard_meth = meth_q[rd_q];
    assign indication_heard_v    = v_q[rd_q];
    assign count                 = count_q;

    // An entry is occupied when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign off[i] = PW'(i) - rd_q;
        assign occ[i] = (CW'(off[i]) < count_q);
        if (DELAY == 0) begin : g_no_delay
            assign aged[i] = 1'b1;
        end else begin : g_delay
            assign aged[i] = (age_q[i] >= DLY);
        end
    end

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (acc) begin
            wr_d = wr_q + 1'b1;
        end
        if (deq) begin
            rd_d = rd_q + 1'b1;
        end
        case ({acc, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!nRST) begin
                meth_q[i] <= '0;
                v_q[i]    <= '0;
                age_q[i]  <= '0;
            end else if (acc && (wr_q == PW'(i))) begin
                meth_q[i] <= request_say_meth;
                v_q[i]    <= request_say_v;
                age_q[i]  <= '0;
            end else if (occ[i] && !aged[i]) begin
                age_q[i]  <= age_q[i] + 4'd1;
            end
        end
    end

`ifdef ECHO_QUEUE_SEQ_EN
    logic [SEQ_WIDTH-1:0] seq_cnt_q;
    logic [SEQ_WIDTH-1:0] seq_q [DEPTH];

    assign indication_heard_seq = seq_q[rd_q];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            seq_cnt_q <= '0;
        end else if (acc) begin
            seq_cnt_q <= seq_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!nRST) begin
                seq_q[i] <= '0;
            end else if (acc && (wr_q == PW'(i))) begin
                seq_q[i] <= seq_cnt_q;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_echo_queue.sv
// tb_echo_queue: directed self-checking bench; instance a has DELAY=1, instance b has DELAY=0.
`default_nettype none

module tb_echo_queue;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        a_ena = 1'b0, b_ena = 1'b0;
    logic [31:0] a_meth = '0, b_meth = '0;
    logic [31:0] a_v = '0, b_v = '0;
    logic        a_rdy, b_rdy;
    logic        a_hena, b_hena;
    logic [31:0] a_hmeth, b_hmeth;
    logic [31:0] a_hv, b_hv;
    logic        a_hrdy = 1'b0, b_hrdy = 1'b0;
    logic [2:0]  a_cnt, b_cnt;
`ifdef ECHO_QUEUE_SEQ_EN
    logic [1:0]  a_seq, b_seq;
`endif

    always #5 CLK = ~CLK;

    echo_queue #(.METH_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .DELAY(1), .SEQ_WIDTH(2)) u_a (
        .CLK(CLK), .nRST(nRST),
        .request_say__ENA(a_ena), .request_say_meth(a_meth), .request_say_v(a_v),
        .request_say__RDY(a_rdy),
        .indication_heard__ENA(a_hena), .indication_heard_meth(a_hmeth), .indication_heard_v(a_hv),
        .indication_heard__RDY(a_hrdy), .count(a_cnt)
`ifdef ECHO_QUEUE_SEQ_EN
        , .indication_heard_seq(a_seq)
`endif
    );

    echo_queue #(.METH_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .DELAY(0), .SEQ_WIDTH(2)) u_b (
        .CLK(CLK), .nRST(nRST),
        .request_say__ENA(b_ena), .request_say_meth(b_meth), .request_say_v(b_v),
        .request_say__RDY(b_rdy),
        .indication_heard__ENA(b_hena), .indication_heard_meth(b_hmeth), .indication_heard_v(b_hv),
        .indication_heard__RDY(b_hrdy), .count(b_cnt)
`ifdef ECHO_QUEUE_SEQ_EN
        , .indication_heard_seq(b_seq)
`endif
    );

    // Inputs change just after the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic test_reset();
        nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK); #1;
        checks++; if (a_rdy !== 1'b1)  begin errors++; $display("FAIL reset_rdy_a got %0b exp 1", a_rdy); end
        checks++; if (a_hena !== 1'b0) begin errors++; $display("FAIL reset_hena_a got %0b exp 0", a_hena); end
        checks++; if (a_cnt !== 3'd0)  begin errors++; $display("FAIL reset_count_a got %0d exp 0", a_cnt); end
        checks++; if (a_hmeth !== 32'd0 || a_hv !== 32'd0) begin errors++; $display("FAIL reset_data_a got meth=%0h v=%0h exp 0/0", a_hmeth, a_hv); end
        checks++; if (b_rdy !== 1'b1 || b_hena !== 1'b0 || b_cnt !== 3'd0) begin errors++; $display("FAIL reset_b got rdy=%0b hena=%0b cnt=%0d exp 1/0/0", b_rdy, b_hena, b_cnt); end
        @(negedge CLK); nRST = 1'b1; a_hrdy = 1'b1; b_hrdy = 1'b1; #1;
        checks++; if (a_hena !== 1'b0 || b_hena !== 1'b0) begin errors++; $display("FAIL post_reset_hena got a=%0b b=%0b exp 0/0", a_hena, b_hena); end
    endtask

    task automatic test_single_echo();
        @(negedge CLK); a_ena = 1'b1; a_meth = 32'd3; a_v = 32'hCAFE; a_hrdy = 1'b1; #1;
        checks++; if (a_cnt !== 3'd0 || a_hena !== 1'b0) begin errors++; $display("FAIL echo_c0 got cnt=%0d hena=%0b exp 0/0", a_cnt, a_hena); end
        @(negedge CLK); a_ena = 1'b0; #1;
        checks++; if (a_cnt !== 3'd1 || a_hena !== 1'b0) begin errors++; $display("FAIL echo_c1 got cnt=%0d hena=%0b exp 1/0", a_cnt, a_hena); end
        @(negedge CLK); #1;
        checks++; if (a_cnt !== 3'd1 || a_hena !== 1'b1) begin errors++; $display("FAIL echo_c2 got cnt=%0d hena=%0b exp 1/1", a_cnt, a_hena); end
        checks++; if (a_hmeth !== 32'd3 || a_hv !== 32'hCAFE) begin errors++; $display("FAIL echo_data got meth=%0h v=%0h exp 3/cafe", a_hmeth, a_hv); end
        @(negedge CLK); #1;
        checks++; if (a_cnt !== 3'd0 || a_hena !== 1'b0) begin errors++; $display("FAIL echo_c3 got cnt=%0d hena=%0b exp 0/0", a_cnt, a_hena); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK); a_hrdy = 1'b0; a_ena = 1'b1; a_v = 32'(k + 1); a_meth = 32'd9; #1;
            checks++; if (a_rdy !== (k < 4)) begin errors++; $display("FAIL fill_rdy_%0d got %0b exp %0b", k, a_rdy, (k < 4)); end
            checks++; if (a_hena !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d got hena=%0b exp 0", k, a_hena); end
        end
        @(negedge CLK); a_ena = 1'b0; #1;
        checks++; if (a_cnt !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", a_cnt); end
        // Full and draining in the same cycle: the new request must not be taken.
        @(negedge CLK); a_hrdy = 1'b1; a_ena = 1'b1; a_v = 32'd99; #1;
        checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL full_deq_rdy got %0b exp 0", a_rdy); end
        checks++; if (a_hena !== 1'b1 || a_hv !== 32'd1) begin errors++; $display("FAIL drain_1 got hena=%0b v=%0d exp 1/1", a_hena, a_hv); end
        for (int k = 2; k <= 4; k++) begin
            @(negedge CLK); a_ena = 1'b0; #1;
            checks++; if (a_hena !== 1'b1 || a_hv !== 32'(k)) begin errors++; $display("FAIL drain_%0d got hena=%0b v=%0d exp 1/%0d", k, a_hena, a_hv, k); end
            checks++; if (a_cnt !== 3'(5 - k)) begin errors++; $display("FAIL drain_cnt_%0d got %0d exp %0d", k, a_cnt, 5 - k); end
        end
        @(negedge CLK); #1;
        checks++; if (a_cnt !== 3'd0 || a_rdy !== 1'b1 || a_hena !== 1'b0) begin errors++; $display("FAIL fill_end got cnt=%0d rdy=%0b hena=%0b exp 0/1/0", a_cnt, a_rdy, a_hena); end
    endtask

    task automatic test_concurrent();
        @(negedge CLK); b_ena = 1'b1; b_meth = 32'd5; b_v = 32'd7; b_hrdy = 1'b1; #1;
        checks++; if (b_hena !== 1'b0) begin errors++; $display("FAIL d0_c0 got hena=%0b exp 0", b_hena); end
        @(negedge CLK); b_ena = 1'b0; #1;
        checks++; if (b_hena !== 1'b1 || b_hv !== 32'd7 || b_hmeth !== 32'd5) begin errors++; $display("FAIL d0_latency got hena=%0b v=%0d meth=%0d exp 1/7/5", b_hena, b_hv, b_hmeth); end
        @(negedge CLK); b_hrdy = 1'b0; b_ena = 1'b1; b_v = 32'd10; #1;
        checks++; if (b_cnt !== 3'd0) begin errors++; $display("FAIL d0_empty got cnt=%0d exp 0", b_cnt); end
        @(negedge CLK); b_v = 32'd11; #1;
        @(negedge CLK); b_hrdy = 1'b1; b_v = 32'd12; #1;
        checks++; if (b_cnt !== 3'd2 || b_hena !== 1'b1 || b_hv !== 32'd10) begin errors++; $display("FAIL conc_c0 got cnt=%0d hena=%0b v=%0d exp 2/1/10", b_cnt, b_hena, b_hv); end
        @(negedge CLK); b_ena = 1'b0; #1;
        checks++; if (b_cnt !== 3'd2 || b_hena !== 1'b1 || b_hv !== 32'd11) begin errors++; $display("FAIL conc_c1 got cnt=%0d hena=%0b v=%0d exp 2/1/11", b_cnt, b_hena, b_hv); end
        @(negedge CLK); #1;
        checks++; if (b_cnt !== 3'd1 || b_hena !== 1'b1 || b_hv !== 32'd12) begin errors++; $display("FAIL conc_c2 got cnt=%0d hena=%0b v=%0d exp 1/1/12", b_cnt, b_hena, b_hv); end
        @(negedge CLK); #1;
        checks++; if (b_cnt !== 3'd0 || b_hena !== 1'b0) begin errors++; $display("FAIL conc_end got cnt=%0d hena=%0b exp 0/0", b_cnt, b_hena); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK); b_ena = 1'b1; b_meth = 32'(i); b_v = 32'h100 + 32'(i); b_hrdy = 1'b1; #1;
            @(negedge CLK); b_ena = 1'b0; #1;
            checks++;
            if (b_hena !== 1'b1 || b_hv !== 32'h100 + 32'(i) || b_hmeth !== 32'(i)) begin
                errors++; $display("FAIL wrap_%0d got hena=%0b v=%0h meth=%0d exp 1/%0h/%0d", i, b_hena, b_hv, b_hmeth, 32'h100 + i, i);
            end
        end
        @(negedge CLK); #1;
        checks++; if (b_cnt !== 3'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", b_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK); a_ena = (k < 4); a_v = 32'(20 + k); a_hrdy = 1'b1; #1;
            checks++; if (a_hena !== (k >= 2)) begin errors++; $display("FAIL b2b_hena_%0d got %0b exp %0b", k, a_hena, (k >= 2)); end
            if (k >= 2) begin
                checks++; if (a_hv !== 32'(18 + k)) begin errors++; $display("FAIL b2b_v_%0d got %0d exp %0d", k, a_hv, 18 + k); end
            end
        end
        @(negedge CLK); a_ena = 1'b0; #1;
        checks++; if (a_cnt !== 3'd0) begin errors++; $display("FAIL b2b_count got %0d exp 0", a_cnt); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); a_hrdy = 1'b0; a_ena = 1'b1; a_v = 32'(40 + k); #1;
        end
        @(negedge CLK); a_ena = 1'b0; nRST = 1'b0; #1;
        checks++; if (a_cnt !== 3'd3) begin errors++; $display("FAIL rstmid_pre got cnt=%0d exp 3", a_cnt); end
        @(negedge CLK); nRST = 1'b1; a_hrdy = 1'b1; #1;
        checks++; if (a_cnt !== 3'd0 || a_rdy !== 1'b1 || a_hena !== 1'b0) begin errors++; $display("FAIL rstmid_post got cnt=%0d rdy=%0b hena=%0b exp 0/1/0", a_cnt, a_rdy, a_hena); end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); #1;
            checks++; if (a_hena !== 1'b0) begin errors++; $display("FAIL rstmid_quiet_%0d got hena=%0b exp 0", k, a_hena); end
        end
    endtask

`ifdef ECHO_QUEUE_SEQ_EN
    task automatic test_seq();
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK); a_ena = (k < 5); a_v = 32'(50 + k); a_hrdy = 1'b1; #1;
            if (k >= 2) begin
                checks++;
                if (a_hena !== 1'b1 || a_seq !== 2'((k - 2) % 4)) begin
                    errors++; $display("FAIL seq_%0d got hena=%0b seq=%0d exp 1/%0d", k, a_hena, a_seq, (k - 2) % 4);
                end
            end
        end
        @(negedge CLK); a_ena = 1'b0; #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_echo();
        test_fill();
        test_concurrent();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef ECHO_QUEUE_SEQ_EN
        test_seq();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
